// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu
// Purpose  : EX-stage execute unit. Single-cycle base integer ALU ops plus
//            RV-M multiply/divide on an iterative datapath (shift-add multiply,
//            restoring divide, one result bit per cycle). Valid/ready
//            handshakes on both the operand side and the result side.
// Ports    : clk, rst_n (synchronous, active low)
//            in_valid/in_ready, op[4:0], rd1, rd2   : operation in
//            out_valid/out_ready, result, zero      : registered result out
// Config   : ALU_MDU_FAST_MUL_EN defined -> MUL* use a single-cycle
//            XLEN x XLEN multiplier; divide remains iterative.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [4:0] c_OP_AND   = 5'b00000;
    localparam logic [4:0] c_OP_OR    = 5'b00001;
    localparam logic [4:0] c_OP_ADD   = 5'b00010;
    localparam logic [4:0] c_OP_XOR   = 5'b00011;
    localparam logic [4:0] c_OP_SLL   = 5'b00100;
    localparam logic [4:0] c_OP_SRL   = 5'b00101;
    localparam logic [4:0] c_OP_SUB   = 5'b00110;
    localparam logic [4:0] c_OP_SRA   = 5'b00111;
    localparam logic [4:0] c_OP_SLT   = 5'b01000;
    localparam logic [4:0] c_OP_SLTU  = 5'b01001;
    localparam logic [4:0] c_OP_SLTI  = 5'b01100;
    localparam logic [4:0] c_OP_SLTIU = 5'b01101;

    localparam logic [SHW:0]    c_CNT_LOAD = (SHW+1)'(XLEN);
    localparam logic [XLEN-1:0] c_MIN      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ONES     = {XLEN{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [SHW:0]      r_cnt;
    logic [2*XLEN-1:0] r_acc;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   r_opnd;    // mul: |multiplicand|; div: |divisor|
    logic              r_neg;     // negate the final value
    logic              r_hi;      // select upper half of r_acc as result
    logic              r_div;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic w_is_m, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic w_neg, w_take_hi, w_div_zero, w_div_ovf, w_div_special;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_imm, w_spec;
    logic [SHW-1:0]  w_sh;

    // 10xxx are the M ops; 11xxx are undefined and return 0 in one cycle
    assign w_is_m     = op[4] & ~op[3];
    assign w_is_div   = op[2];
    assign w_a_signed = w_is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign w_b_signed = w_is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign w_a_neg    = w_a_signed & rd1[XLEN-1];
    assign w_b_neg    = w_b_signed & rd2[XLEN-1];
    assign w_abs_a    = w_a_neg ? -rd1 : rd1;
    assign w_abs_b    = w_b_neg ? -rd2 : rd2;
    // remainder follows the dividend sign; quotient/product the sign xor
    assign w_neg      = (w_is_div & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_take_hi  = w_is_div ? op[1] : (op[1:0] != 2'b00);
    assign w_sh       = rd2[SHW-1:0];

    assign w_div_zero    = (rd2 == '0);
    assign w_div_ovf     = ~op[0] & (rd1 == c_MIN) & (rd2 == c_ONES);
    assign w_div_special = w_div_zero | w_div_ovf;
    assign w_spec        = w_div_zero ? (op[1] ? rd1 : c_ONES)
                                      : (op[1] ? '0  : c_MIN);

    generate
        if (XLEN >= 16) begin : g_imm_wide
            assign w_imm = {{(XLEN-12){rd2[11]}}, rd2[11:0]};
        end else begin : g_imm_narrow
            // the operand is narrower than the immediate field
            assign w_imm = rd2;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Base ALU
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_alu;
    always_comb begin
        w_alu = '0;
        case (op)
            c_OP_AND:   w_alu = rd1 & rd2;
            c_OP_OR:    w_alu = rd1 | rd2;
            c_OP_ADD:   w_alu = rd1 + rd2;
            c_OP_XOR:   w_alu = rd1 ^ rd2;
            c_OP_SLL:   w_alu = rd1 << w_sh;
            c_OP_SRL:   w_alu = rd1 >> w_sh;
            c_OP_SUB:   w_alu = rd1 - rd2;
            c_OP_SRA:   w_alu = $signed(rd1) >>> w_sh;
            c_OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(rd1) < $signed(rd2))};
            c_OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (rd1 < rd2)};
            c_OP_SLTI:  w_alu = {{(XLEN-1){1'b0}}, ($signed(rd1) < $signed(w_imm))};
            c_OP_SLTIU: w_alu = {{(XLEN-1){1'b0}}, (rd1 < w_imm)};
            default:    w_alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional single-cycle multiplier
    // ------------------------------------------------------------------
    logic            w_fast_mul;
    logic [XLEN-1:0] w_fmul_res;
`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
    // extend both operands to 2*XLEN; the low 2*XLEN product bits are exact
    assign w_fa       = {{XLEN{w_a_neg}}, rd1};
    assign w_fb       = {{XLEN{w_b_neg}}, rd2};
    assign w_fprod    = w_fa * w_fb;
    assign w_fast_mul = 1'b1;
    assign w_fmul_res = (op[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
    assign w_fast_mul = 1'b0;
    assign w_fmul_res = '0;
`endif

    logic            w_go_busy;
    logic [XLEN-1:0] w_quick;
    assign w_go_busy = w_is_m & ~(w_is_div & w_div_special) & ~(~w_is_div & w_fast_mul);
    assign w_quick   = ~w_is_m ? w_alu : (w_is_div ? w_spec : w_fmul_res);

    // ------------------------------------------------------------------
    // Iterative step
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_sum, w_rsh, w_diff;
    logic [2*XLEN-1:0] w_mstep, w_dstep, w_step, w_mneg;
    logic [XLEN-1:0]   w_sel, w_fix;
    logic [SHW:0]      w_cnt_next;

    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_mstep = {w_sum, r_acc[XLEN-1:1]};

    assign w_rsh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff  = w_rsh - {1'b0, r_opnd};
    assign w_dstep = w_diff[XLEN] ? {w_rsh[XLEN-1:0],  r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_step     = r_div ? w_dstep : w_mstep;
    assign w_cnt_next = r_cnt - (SHW+1)'(1);

    // the last step and the sign fixup share a cycle so M ops finish in XLEN+1
    always_comb begin
        w_mneg = r_neg ? -w_step : w_step;
        w_sel  = r_hi ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
        if (r_div) begin
            w_fix = r_neg ? -w_sel : w_sel;
        end else begin
            w_fix = r_hi ? w_mneg[2*XLEN-1:XLEN] : w_mneg[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid) w_state_next = w_go_busy ? c_ST_BUSY : c_ST_DONE;
            c_ST_BUSY: if (w_cnt_next == '0) w_state_next = c_ST_DONE;
            c_ST_DONE: if (out_ready) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_ST_IDLE);
        out_valid = (r_state == c_ST_DONE);
        result    = r_result;
        zero      = r_zero;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_hi     <= 1'b0;
            r_div    <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        if (w_go_busy) begin
                            r_cnt  <= c_CNT_LOAD;
                            r_opnd <= w_is_div ? w_abs_b : w_abs_a;
                            r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                            r_neg  <= w_neg;
                            r_hi   <= w_take_hi;
                            r_div  <= w_is_div;
                        end else begin
                            r_result <= w_quick;
                            r_zero   <= (w_quick == '0);
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_acc <= w_step;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == '0) begin
                        r_result <= w_fix;
                        r_zero   <= (w_fix == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mdu
// Purpose  : Self-checking bench for alu_mdu. Directed cases on a 32-bit
//            instance, then random back-to-back ops with random result stalls
//            on 32-bit and 8-bit instances against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv0, ir0, ov0, ordy0, z0;
    logic [4:0]  op0;
    logic [31:0] a0, b0, r0;
    logic        iv1, ir1, ov1, ordy1, z1;
    logic [4:0]  op1;
    logic [7:0]  a1, b1, r1;

    int n_checks = 0;
    int n_errors = 0;

    alu_mdu #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .op(op0),
        .rd1(a0), .rd2(b0), .out_valid(ov0), .out_ready(ordy0),
        .result(r0), .zero(z0)
    );

    alu_mdu #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1),
        .rd1(a1), .rd2(b1), .out_valid(ov1), .out_ready(ordy1),
        .result(r1), .zero(z1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic f_ir(int k);           return (k == 0) ? ir0 : ir1; endfunction
    function automatic logic f_ov(int k);           return (k == 0) ? ov0 : ov1; endfunction
    function automatic logic f_z(int k);            return (k == 0) ? z0  : z1;  endfunction
    function automatic logic [31:0] f_res(int k);   return (k == 0) ? r0 : {24'h0, r1}; endfunction

    task automatic drive(input int k, input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin iv0 = v; op0 = op; a0 = a; b0 = b; end
        else        begin iv1 = v; op1 = op; a1 = a[7:0]; b1 = b[7:0]; end
    endtask

    task automatic set_ordy(input int k, input logic v);
        if (k == 0) ordy0 = v; else ordy1 = v;
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic longint sx(longint unsigned v, int w);
        return $signed(v << (64 - w)) >>> (64 - w);
    endfunction

    function automatic logic [31:0] model(int w, logic [4:0] op, logic [31:0] a, logic [31:0] b);
        longint unsigned mask, ua, ub, pu;
        longint sa, sb, imm, r, mn;
        int sh;
        mask = (64'd1 << w) - 1;
        ua = a & mask;  ub = b & mask;
        sa = sx(ua, w); sb = sx(ub, w);
        sh = int'(ub % w);
        mn = -(64'sd1 <<< (w - 1));
        imm = (w >= 12) ? sx(ub & 64'hfff, 12) : sb;
        r = 0;
        case (op)
            5'b00000: r = ua & ub;
            5'b00001: r = ua | ub;
            5'b00010: r = ua + ub;
            5'b00011: r = ua ^ ub;
            5'b00100: r = ua << sh;
            5'b00101: r = ua >> sh;
            5'b00110: r = ua - ub;
            5'b00111: r = sa >>> sh;
            5'b01000: r = (sa < sb) ? 1 : 0;
            5'b01001: r = (ua < ub) ? 1 : 0;
            5'b01100: r = (sa < imm) ? 1 : 0;
            5'b01101: begin pu = imm & mask; r = (ua < pu) ? 1 : 0; end
            5'b10000: r = sa * sb;
            5'b10001: r = (sa * sb) >>> w;
            5'b10010: r = (sa * longint'(ub)) >>> w;
            5'b10011: begin pu = ua * ub; r = pu >> w; end
            5'b10100: r = (ub == 0) ? -1 : ((sa == mn && sb == -1) ? mn : sa / sb);
            5'b10101: r = (ub == 0) ? -1 : ua / ub;
            5'b10110: r = (ub == 0) ? sa : ((sa == mn && sb == -1) ? 0 : sa % sb);
            5'b10111: r = (ub == 0) ? ua : ua % ub;
            default:  r = 0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int exp_lat(int w, logic [4:0] op, logic [31:0] a, logic [31:0] b);
        longint unsigned mask;
        mask = (64'd1 << w) - 1;
        if (op[4:3] != 2'b10) return 1;
        if (!op[2]) begin
`ifdef ALU_MDU_FAST_MUL_EN
            return 1;
`else
            return w + 1;
`endif
        end
        if ((b & mask) == 0) return 1;
        if (!op[0] && (a & mask) == (64'd1 << (w - 1)) && (b & mask) == mask) return 1;
        return w + 1;
    endfunction

    // One full transaction: issue, measure latency, stall, handshake.
    // Entered and left at #1 after a rising edge.
    task automatic do_op(input int k, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall, input logic [31:0] exp,
                         input int lat_exp, input string tag);
        int t;
        int lat;
        t = 0;
        while (!f_ir(k) && t < 100) begin @(posedge clk); #1; t++; end
        check({tag, "_ready"}, {31'h0, f_ir(k)}, 32'h1);
        drive(k, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(k, 1'b0, op, a, b);
        lat = 1;
        while (!f_ov(k) && lat < 200) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check({tag, "_res"}, f_res(k), exp);
        check({tag, "_zero"}, {31'h0, f_z(k)}, {31'h0, (exp == 32'h0)});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_res"}, f_res(k), exp);
            check({tag, "_hold_busy"}, {30'h0, f_ov(k), f_ir(k)}, 32'h2);
        end
        set_ordy(k, 1'b1);
        @(posedge clk); #1;
        set_ordy(k, 1'b0);
        check({tag, "_taken"}, {31'h0, f_ov(k)}, 32'h0);
    endtask

    task automatic directed(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int stall, input logic [31:0] exp, input string tag);
        do_op(0, op, a, b, stall, exp, exp_lat(32, op, a, b), tag);
    endtask

    function automatic logic [31:0] rand_opnd(int w);
        logic [31:0] mask;
        mask = 32'((64'd1 << w) - 1);
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return mask;
            3: return 32'(64'd1 << (w - 1));
            4: return 32'($urandom_range(0, 15));
            default: return $urandom & mask;
        endcase
    endfunction

    logic [4:0] codes [22] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                               5'd12, 5'd13, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21,
                               5'd22, 5'd23, 5'd10, 5'd27};

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 5'd0, 32'h0, 32'h0);
        drive(1, 1'b0, 5'd0, 32'h0, 32'h0);
        ordy0 = 1'b0; ordy1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state32", {28'h0, ir0, ov0, z0, 1'b0}, 32'ha);
        check("rst_res32", r0, 32'h0);
        check("rst_state8", {28'h0, ir1, ov1, z1, 1'b0}, 32'ha);
        check("rst_res8", {24'h0, r1}, 32'h0);
        rst_n = 1'b1;

        // directed cases
        directed(5'b00010, 32'd7, 32'd5, 3, 32'd12, "add");
        directed(5'b00110, 32'd5, 32'd5, 0, 32'd0, "sub");
        directed(5'b00111, 32'h80000000, 32'd4, 0, 32'hF8000000, "sra");
        directed(5'b01100, 32'hFFFFFFFE, 32'h00000FFF, 0, 32'd1, "slti");
        directed(5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0, "mulh");
        directed(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, "mulhu");
        directed(5'b10100, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, "div");
        directed(5'b10110, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, "rem");
        directed(5'b10101, 32'd7, 32'd0, 0, 32'hFFFFFFFF, "divu_z");
        directed(5'b10111, 32'd7, 32'd0, 0, 32'd7, "remu_z");
        directed(5'b10100, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, "div_ovf");
        directed(5'b10110, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, "rem_ovf");
        directed(5'b11010, 32'd9, 32'd3, 0, 32'h0, "undef");

        // reset in the middle of a divide
        drive(0, 1'b1, 5'b10100, 32'd1000, 32'd7);
        @(posedge clk); #1;
        drive(0, 1'b0, 5'b10100, 32'd1000, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_state", {30'h0, ov0, ir0}, 32'h1);
        check("abort_res", r0, 32'h0);
        rst_n = 1'b1;
        directed(5'b00010, 32'd1, 32'd2, 0, 32'd3, "add_after_rst");

        // random back-to-back traffic on both widths
        for (int k = 0; k < 2; k++) begin
            int w;
            w = (k == 0) ? 32 : 8;
            for (int n = 0; n < 250; n++) begin
                logic [4:0]  op;
                logic [31:0] a, b;
                op = codes[$urandom_range(0, 21)];
                a  = rand_opnd(w);
                b  = rand_opnd(w);
                do_op(k, op, a, b, $urandom_range(0, 2), model(w, op, a, b),
                      exp_lat(w, op, a, b), (k == 0) ? "rnd32" : "rnd8");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
